// File: rtl/tetris_video_pkg.sv
// Shared constants and types for the Tetris video path: board geometry, colours,
// palette, beam FSM states and the per-pixel pipeline tag.
package tetris_video_pkg;

  localparam int CELL_SHIFT = 4;
  localparam int BOARD_COLS = 10;
  localparam int BOARD_ROWS = 20;
  localparam int BORDER_W   = 4;

  localparam logic [9:0] BOARD_X0 = 10'd240;
  localparam logic [8:0] BOARD_Y0 = 9'd80;
  localparam logic [9:0] BOARD_X1 = BOARD_X0 + 10'(BOARD_COLS << CELL_SHIFT);
  localparam logic [8:0] BOARD_Y1 = BOARD_Y0 + 9'(BOARD_ROWS << CELL_SHIFT);

  // Border ring bounds; upper bounds are exclusive like the board's.
  localparam logic [9:0] BORDER_X0 = BOARD_X0 - 10'(BORDER_W);
  localparam logic [9:0] BORDER_X1 = BOARD_X1 + 10'(BORDER_W);
  localparam logic [8:0] BORDER_Y0 = BOARD_Y0 - 9'(BORDER_W);
  localparam logic [8:0] BORDER_Y1 = BOARD_Y1 + 9'(BORDER_W);

  localparam logic [7:0] BORDER_RGB = 8'hFF;
  localparam logic [7:0] BG_RGB     = 8'h00;
  localparam logic [7:0] GRID_RGB   = 8'h24;

  localparam logic [7:0] PALETTE [8] = '{
    8'h00, 8'h1F, 8'hFC, 8'hA2, 8'h1C, 8'hE0, 8'h03, 8'hF0
  };

  typedef enum logic [1:0] {
    SEEK_FRAME,
    BLANK,
    ACTIVE
  } beam_state_e;

  typedef enum logic [1:0] {
    REGION_BG,
    REGION_BORDER,
    REGION_BOARD
  } region_e;

  typedef struct packed {
    logic    valid;
    region_e region;
  } pix_tag_t;

  localparam pix_tag_t TAG_IDLE = '{valid: 1'b0, region: REGION_BG};

  // row*10+col using only shifts and adds.
  function automatic logic [7:0] cell_index(input logic [4:0] row, input logic [3:0] col);
    return ({3'b000, row} << 3) + ({3'b000, row} << 1) + {4'b0000, col};
  endfunction

endpackage

// File: rtl/beam_tracker.sv
// Follows the timing generator's pixel_en/v_sync to maintain the beam position
// (sub-pixel, x, y), the SEEK_FRAME/BLANK/ACTIVE state and the frame_start pulse.
module beam_tracker
  import tetris_video_pkg::*;
#(
  parameter int CLKS_PER_PIXEL = 20,
  parameter int H_PIXELS       = 640,
  parameter int V_PIXELS       = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pixel_en,
  input  logic       v_sync,
  output logic [9:0] pixel_x,
  output logic [8:0] pixel_y,
  output logic       frame_start,
  output logic       pixel_valid
);

  localparam int               SUB_W    = $clog2(CLKS_PER_PIXEL);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CLKS_PER_PIXEL - 1);
  localparam logic [9:0]       X_LAST   = 10'(H_PIXELS - 1);
  localparam logic [8:0]       Y_LAST   = 9'(V_PIXELS - 1);

  beam_state_e      state_q, state_d;
  logic             pixel_en_q, v_sync_q;
  logic [SUB_W-1:0] sub;
  logic             vs_rise, pe_rise, pe_fall;

  assign vs_rise     = v_sync & ~v_sync_q;
  assign pe_rise     = pixel_en & ~pixel_en_q;
  assign pe_fall     = ~pixel_en & pixel_en_q;
  assign pixel_valid = (state_q == ACTIVE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation order cannot change the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_en_q  <= 1'b0;
      v_sync_q    <= 1'b0;
      frame_start <= 1'b0;
      state_q     <= SEEK_FRAME;
    end else begin
      pixel_en_q  <= pixel_en;
      v_sync_q    <= v_sync;
      frame_start <= vs_rise;
      state_q     <= state_d;
    end
  end

  // NOTE: state_d is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SEEK_FRAME: state_d = SEEK_FRAME;
      BLANK:      if (pe_rise) state_d = ACTIVE;
      ACTIVE:     if (pe_fall) state_d = BLANK;
      default:    state_d = SEEK_FRAME;
    endcase
    // A new frame overrides whatever the line logic wanted.
    if (vs_rise) state_d = BLANK;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sub     <= '0;
      pixel_x <= '0;
      pixel_y <= '0;
    end else if (vs_rise) begin
      sub     <= '0;
      pixel_x <= '0;
      pixel_y <= '0;
    end else if (state_q == ACTIVE) begin
      if (pe_fall) begin
        // End of line: any partially counted pixel is dropped.
        sub     <= '0;
        pixel_x <= '0;
        if (pixel_y != Y_LAST) pixel_y <= pixel_y + 9'd1;
      end else if (sub == SUB_LAST) begin
        sub <= '0;
        if (pixel_x != X_LAST) pixel_x <= pixel_x + 10'd1;
      end else begin
        sub <= sub + 1'b1;
      end
    end
  end

endmodule

// File: rtl/board_pixel_source.sv
// Renders the Tetris board, its border and background onto rgb_8 with a 3-cycle
// pipeline behind the beam position. Optional BOARD_GRID_LINES_EN draws cell outlines.
module board_pixel_source
  import tetris_video_pkg::*;
#(
  parameter int CLKS_PER_PIXEL = 20,
  parameter int H_PIXELS       = 640,
  parameter int V_PIXELS       = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pixel_en,
  input  logic       v_sync,
  output logic [7:0] cell_addr,
  input  logic [2:0] cell_data,
  output logic [7:0] rgb_8,
  output logic [9:0] pixel_x,
  output logic [8:0] pixel_y,
  output logic       frame_start
);

  logic pixel_valid;

  beam_tracker #(
    .CLKS_PER_PIXEL(CLKS_PER_PIXEL),
    .H_PIXELS      (H_PIXELS),
    .V_PIXELS      (V_PIXELS)
  ) u_beam (
    .clk        (clk),
    .rst        (rst),
    .pixel_en   (pixel_en),
    .v_sync     (v_sync),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .frame_start(frame_start),
    .pixel_valid(pixel_valid)
  );

  logic [9:0] dx;
  logic [8:0] dy;
  logic [4:0] row;
  logic [3:0] col;
  logic       in_board, in_ring;
  pix_tag_t   tag0, tag1, tag2;
  logic [7:0] rgb_next;

  always_comb begin
    dx       = pixel_x - BOARD_X0;
    dy       = pixel_y - BOARD_Y0;
    row      = 5'(dy >> CELL_SHIFT);
    col      = 4'(dx >> CELL_SHIFT);
    in_board = (pixel_x >= BOARD_X0) && (pixel_x < BOARD_X1) &&
               (pixel_y >= BOARD_Y0) && (pixel_y < BOARD_Y1);
    in_ring  = (pixel_x >= BORDER_X0) && (pixel_x < BORDER_X1) &&
               (pixel_y >= BORDER_Y0) && (pixel_y < BORDER_Y1);
    tag0.valid  = pixel_valid;
    tag0.region = in_board ? REGION_BOARD : (in_ring ? REGION_BORDER : REGION_BG);
  end

  // NOTE: the tag pipeline is reset so no stale "valid" pixel can emit colour
  // straight out of reset; cell_addr is reset for a defined first RAM read.
  always_ff @(posedge clk) begin
    if (rst) begin
      cell_addr <= '0;
      tag1      <= TAG_IDLE;
      tag2      <= TAG_IDLE;
    end else begin
      // Off-board pixels leave the RAM address untouched.
      if (in_board) cell_addr <= cell_index(row, col);
      tag1 <= tag0;
      tag2 <= tag1;
    end
  end

`ifdef BOARD_GRID_LINES_EN
  logic grid0, grid1, grid2;

  assign grid0 = (dx[CELL_SHIFT-1:0] == '0) || (dy[CELL_SHIFT-1:0] == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      grid1 <= 1'b0;
      grid2 <= 1'b0;
    end else begin
      grid1 <= grid0;
      grid2 <= grid1;
    end
  end
`endif

  // tag2 lines up with cell_data, which arrives one cycle after cell_addr.
  always_comb begin
    rgb_next = BG_RGB;
    if (tag2.valid) begin
      unique case (tag2.region)
        REGION_BOARD:  rgb_next = PALETTE[cell_data];
        REGION_BORDER: rgb_next = BORDER_RGB;
        default:       rgb_next = BG_RGB;
      endcase
`ifdef BOARD_GRID_LINES_EN
      if (tag2.region == REGION_BOARD && grid2) rgb_next = GRID_RGB;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rgb_8 <= BG_RGB;
    else     rgb_8 <= rgb_next;
  end

endmodule

// File: tb/tb_board_pixel_source.sv
// Randomized bench for board_pixel_source: a cycle-count beam model plus a
// region/palette colour function predict every output on every clock.
module tb_board_pixel_source;

  localparam int CPP  = 20;
  localparam int HP   = 640;
  localparam int VP   = 480;
  localparam int XMAX = HP - 1;
  localparam int YMAX = VP - 1;

`ifdef BOARD_GRID_LINES_EN
  localparam logic [7:0] GRID_EXP = 8'h24;
`else
  localparam logic [7:0] GRID_EXP = 8'hFC;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       pixel_en;
  logic       v_sync;
  logic [2:0] cell_data;
  logic [7:0] cell_addr;
  logic [7:0] rgb_8;
  logic [9:0] pixel_x;
  logic [8:0] pixel_y;
  logic       frame_start;

  board_pixel_source #(
    .CLKS_PER_PIXEL(CPP),
    .H_PIXELS      (HP),
    .V_PIXELS      (VP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pixel_en   (pixel_en),
    .v_sync     (v_sync),
    .cell_addr  (cell_addr),
    .cell_data  (cell_data),
    .rgb_8      (rgb_8),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Beam model: position derives from cycles elapsed since the line started.
  bit         m_armed, m_in_line, m_pe_prev, m_vs_prev, m_fs;
  int         m_count, m_y;
  int         h_x [3];
  int         h_y [3];
  bit         h_v [3];
  logic [7:0] m_addr, m_rgb;

  function automatic int model_x();
    if (!m_in_line) return 0;
    return (m_count / CPP > XMAX) ? XMAX : m_count / CPP;
  endfunction

  function automatic bit on_board(input int x, input int y);
    return x >= 240 && x < 400 && y >= 80 && y < 400;
  endfunction

  function automatic logic [7:0] palette(input logic [2:0] i);
    case (i)
      3'd0: return 8'h00;
      3'd1: return 8'h1F;
      3'd2: return 8'hFC;
      3'd3: return 8'hA2;
      3'd4: return 8'h1C;
      3'd5: return 8'hE0;
      3'd6: return 8'h03;
      default: return 8'hF0;
    endcase
  endfunction

  function automatic logic [7:0] pixel_colour(input int x, input int y, input bit v,
                                              input logic [2:0] cd);
    if (!v) return 8'h00;
    if (on_board(x, y)) begin
`ifdef BOARD_GRID_LINES_EN
      if ((x - 240) % 16 == 0 || (y - 80) % 16 == 0) return 8'h24;
`endif
      return palette(cd);
    end
    if (x >= 236 && x < 404 && y >= 76 && y < 404) return 8'hFF;
    return 8'h00;
  endfunction

  function automatic logic [7:0] board_index(input int x, input int y);
    return 8'(((y - 80) / 16) * 10 + (x - 240) / 16);
  endfunction

  task automatic model_reset();
    m_armed = 0; m_in_line = 0; m_pe_prev = 0; m_vs_prev = 0; m_fs = 0;
    m_count = 0; m_y = 0; m_addr = 8'h00; m_rgb = 8'h00;
    for (int i = 0; i < 3; i++) begin
      h_x[i] = 0; h_y[i] = 0; h_v[i] = 0;
    end
  endtask

  task automatic model_edge(input bit pe, input bit vs);
    bit vs_rise, pe_rise, pe_fall;
    vs_rise = vs && !m_vs_prev;
    pe_rise = pe && !m_pe_prev;
    pe_fall = !pe && m_pe_prev;
    m_rgb = pixel_colour(h_x[2], h_y[2], h_v[2], cell_data);
    if (on_board(h_x[0], h_y[0])) m_addr = board_index(h_x[0], h_y[0]);
    for (int i = 2; i > 0; i--) begin
      h_x[i] = h_x[i-1]; h_y[i] = h_y[i-1]; h_v[i] = h_v[i-1];
    end
    m_fs = vs_rise;
    if (vs_rise) begin
      m_armed = 1; m_in_line = 0; m_y = 0; m_count = 0;
    end else if (m_armed) begin
      if (m_in_line && pe_fall) begin
        m_in_line = 0;
        m_y = (m_y < YMAX) ? m_y + 1 : YMAX;
      end else if (m_in_line) begin
        m_count++;
      end else if (pe_rise) begin
        m_in_line = 1; m_count = 0;
      end
    end
    h_x[0] = model_x(); h_y[0] = m_y; h_v[0] = m_in_line;
    m_pe_prev = pe; m_vs_prev = vs;
  endtask

  task automatic check_outputs();
    check("pixel_x",     32'(pixel_x),     32'(model_x()));
    check("pixel_y",     32'(pixel_y),     32'(m_y));
    check("frame_start", 32'(frame_start), 32'(m_fs));
    check("cell_addr",   32'(cell_addr),   32'(m_addr));
    check("rgb_8",       32'(rgb_8),       32'(m_rgb));
  endtask

  task automatic step(input bit pe, input bit vs);
    pixel_en = pe;
    v_sync   = vs;
    @(posedge clk);
    model_edge(pe, vs);
    #1;
    check_outputs();
  endtask

  task automatic apply_reset(input int cycles, input bit pe);
    rst = 1'b1; pixel_en = pe; v_sync = 1'b0;
    repeat (cycles) @(posedge clk);
    model_reset();
    #1;
    check_outputs();
    rst = 1'b0;
  endtask

  task automatic short_lines(input int n);
    for (int i = 0; i < n; i++) begin
      repeat (4) step(1'b1, 1'b0);
      repeat (4) step(1'b0, 1'b0);
    end
  endtask

  task automatic frame_pulse();
    repeat (2) step(1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0);
  endtask

  task automatic run_to_x(input int target);
    int budget;
    budget = (target + 2) * CPP + 8;
    while (model_x() != target && budget > 0) begin
      step(1'b1, 1'b0);
      budget--;
    end
    check("reach_x", 32'(pixel_x), 32'(target));
  endtask

  task automatic end_line();
    repeat (6) step(1'b0, 1'b0);
  endtask

  initial begin : main
    int len, vs_at, budget;
    rst = 1'b1; pixel_en = 1'b0; v_sync = 1'b0; cell_data = 3'd0;
    model_reset();

    apply_reset(3, 1'b0);
    check("rst_rgb",  32'(rgb_8),     32'h00);
    check("rst_addr", 32'(cell_addr), 32'h00);
    check("rst_fs",   32'(frame_start), 32'h0);

    // pixel_en activity before any frame is ignored
    repeat (50) step(1'b1, 1'b0);
    repeat (5)  step(1'b0, 1'b0);
    check("seek_x",   32'(pixel_x), 32'd0);
    check("seek_rgb", 32'(rgb_8),   32'h00);

    step(1'b0, 1'b1);
    check("fs_pulse",   32'(frame_start), 32'h1);
    check("y_after_vs", 32'(pixel_y),     32'd0);
    step(1'b0, 1'b1);
    check("fs_one_cycle", 32'(frame_start), 32'h0);
    repeat (3) step(1'b0, 1'b0);

    short_lines(80);
    check("y80", 32'(pixel_y), 32'd80);
    cell_data = 3'd5;
    run_to_x(240);
    repeat (3) step(1'b1, 1'b0);
    check("rgb_first_cell",  32'(rgb_8),     32'hE0);
    check("addr_first_cell", 32'(cell_addr), 32'd0);
    end_line();

    short_lines(119);
    check("y200", 32'(pixel_y), 32'd200);
    cell_data = 3'($urandom);
    run_to_x(100);
    repeat (3) step(1'b1, 1'b0);
    check("rgb_bg_left", 32'(rgb_8), 32'h00);
    run_to_x(236);
    repeat (3) step(1'b1, 1'b0);
    check("rgb_border", 32'(rgb_8), 32'hFF);
    run_to_x(404);
    repeat (3) step(1'b1, 1'b0);
    check("rgb_bg_right", 32'(rgb_8), 32'h00);
    end_line();

    short_lines(198);
    check("y399", 32'(pixel_y), 32'd399);
    run_to_x(399);
    repeat (3) step(1'b1, 1'b0);
    check("addr_last_cell", 32'(cell_addr), 32'd199);
    run_to_x(639);
    repeat (2 * CPP) step(1'b1, 1'b0);
    check("x_saturate", 32'(pixel_x), 32'd639);
    end_line();
    short_lines(85);
    check("y_saturate", 32'(pixel_y), 32'd479);

    // grid line at x=256, y=90
    frame_pulse();
    short_lines(90);
    cell_data = 3'd2;
    run_to_x(256);
    repeat (3) step(1'b1, 1'b0);
    check("grid_cell", 32'(rgb_8), 32'(GRID_EXP));

    // pixel_en fall at sub=7 coinciding with a v_sync rise
    run_to_x(260);
    budget = CPP;
    while (m_count % CPP != 7 && budget > 0) begin
      step(1'b1, 1'b0);
      budget--;
    end
    step(1'b0, 1'b1);
    check("coll_x",  32'(pixel_x),     32'd0);
    check("coll_y",  32'(pixel_y),     32'd0);
    check("coll_fs", 32'(frame_start), 32'h1);
    repeat (4) step(1'b0, 1'b0);

    // reset mid-line, then the block must wait for a new frame
    short_lines(5);
    repeat (300) step(1'b1, 1'b0);
    apply_reset(1, 1'b1);
    check("midrst_x",   32'(pixel_x), 32'd0);
    check("midrst_y",   32'(pixel_y), 32'd0);
    check("midrst_rgb", 32'(rgb_8),   32'h00);
    repeat (100) step(1'b1, 1'b0);
    check("rewait_x", 32'(pixel_x), 32'd0);
    repeat (4) step(1'b0, 1'b0);

    // randomized lines, occasional frame restarts
    frame_pulse();
    for (int it = 0; it < 5; it++) begin
      short_lines(int'($urandom_range(0, 100)));
      cell_data = 3'($urandom);
      len   = int'($urandom_range(200, 6000));
      vs_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, len - 1)) : -1;
      for (int k = 0; k < len; k++) begin
        if (k % 97 == 0) cell_data = 3'($urandom);
        step(1'b1, (vs_at >= 0) && (k >= vs_at) && (k < vs_at + 3));
      end
      repeat ($urandom_range(2, 30)) step(1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
